// File: rtl/mem_stage_pkg.sv
// Shared core package: pipeline width defaults, memory-op/size encodings and
// the memory-stage FSM state type.
package mem_stage_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned RD_W   = 5;

    typedef enum logic [1:0] {
        MOP_NONE  = 2'b00,
        MOP_LOAD  = 2'b01,
        MOP_STORE = 2'b10,
        MOP_RSVD  = 2'b11
    } mop_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int unsigned WORD = 32,
    parameter int unsigned LB   = $clog2(WORD/8)
) (
    input  logic [LB-1:0]     addr,   // byte offset within the word
    input  size_e             size,
    input  logic              sext,
    input  logic [WORD-1:0]   sdata,
    input  logic [WORD-1:0]   rdata,
    output logic [WORD/8-1:0] be,
    output logic [WORD-1:0]   wdata,
    output logic [WORD-1:0]   ldata
);

    localparam int unsigned NB = WORD / 8;

    logic [LB+2:0]   sh;
    logic [WORD-1:0] rsh;

    assign sh  = {addr, 3'b000};
    assign rsh = rdata >> sh;

    always_comb begin
        be    = '0;
        wdata = '0;
        ldata = '0;
        case (size)
            SZ_BYTE: begin
                be    = NB'(1) << addr;
                wdata = {NB{sdata[7:0]}};
                ldata = {{(WORD-8){sext & rsh[7]}}, rsh[7:0]};
            end
            SZ_HALF: begin
                be    = NB'(3) << addr;
                wdata = {(NB/2){sdata[15:0]}};
                ldata = {{(WORD-16){sext & rsh[15]}}, rsh[15:0]};
            end
            SZ_WORD: begin
                be    = '1;
                wdata = sdata;
                ldata = rsh;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one load/store to memory with timeout, or
// passes ALU results straight to register-file writeback.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned WORD = WORD_W,
    parameter int unsigned ADDR = ADDR_W,
    parameter int unsigned W_RD = RD_W,
    parameter int unsigned TMO  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              v_i,
    output logic              stall_o,
    input  logic [1:0]        mop_i,
    input  logic [1:0]        size_i,
    input  logic              sext_i,
    input  logic [ADDR-1:0]   addr_i,
    input  logic [WORD-1:0]   sdata_i,
    input  logic              wb_i,
    input  logic [W_RD-1:0]   rd_num_i,
    input  logic [WORD-1:0]   rd_data_i,
    output logic              wb_o,
    output logic [W_RD-1:0]   rd_num_o,
    output logic [WORD-1:0]   rd_data_o,
    output logic              req_o,
    output logic              we_o,
    output logic [ADDR-1:0]   maddr_o,
    output logic [WORD/8-1:0] be_o,
    output logic [WORD-1:0]   wdata_o,
    input  logic              ack_i,
    input  logic [WORD-1:0]   rdata_i,
    output logic              err_o
);

    localparam int unsigned LB = $clog2(WORD/8);
    localparam int unsigned CW = $clog2(TMO+1);

    state_e          state;
    logic [CW-1:0]   cnt;
    logic            load_q;
    logic            sext_q;
    size_e           size_q;
    logic [LB-1:0]   lane_q;
    logic [W_RD-1:0] rd_q;

    mop_e            mop;
    size_e           size;
    logic            misal;
    logic [LB-1:0]   al_lane;
    size_e           al_size;
    logic            al_sext;
    logic [WORD/8-1:0] al_be;
    logic [WORD-1:0] al_wdata;
    logic [WORD-1:0] al_ldata;

    assign mop     = mop_e'(mop_i);
    assign size    = size_e'(size_i);
    assign stall_o = (state == ST_REQ);

    // In REQ the aligner works on the latched op so the load lane can be extracted on ack.
    assign al_lane = stall_o ? lane_q : addr_i[LB-1:0];
    assign al_size = stall_o ? size_q : size;
    assign al_sext = stall_o ? sext_q : sext_i;

    always_comb begin
        misal = 1'b0;
        case (size)
            SZ_HALF: misal = addr_i[0];
            SZ_WORD: misal = |addr_i[LB-1:0];
            SZ_RSVD: misal = 1'b1;
            default: ;
        endcase
    end

    mem_align #(
        .WORD (WORD),
        .LB   (LB)
    ) u_align (
        .addr  (al_lane),
        .size  (al_size),
        .sext  (al_sext),
        .sdata (sdata_i),
        .rdata (rdata_i),
        .be    (al_be),
        .wdata (al_wdata),
        .ldata (al_ldata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            load_q    <= 1'b0;
            sext_q    <= 1'b0;
            size_q    <= SZ_BYTE;
            lane_q    <= '0;
            rd_q      <= '0;
            wb_o      <= 1'b0;
            rd_num_o  <= '0;
            rd_data_o <= '0;
            req_o     <= 1'b0;
            we_o      <= 1'b0;
            maddr_o   <= '0;
            be_o      <= '0;
            wdata_o   <= '0;
            err_o     <= 1'b0;
        end else begin
            wb_o  <= 1'b0;
            err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (v_i) begin
                        case (mop)
                            MOP_NONE: begin
                                wb_o      <= wb_i;
                                rd_num_o  <= rd_num_i;
                                rd_data_o <= rd_data_i;
                            end
                            MOP_LOAD, MOP_STORE: begin
                                if (misal) begin
                                    err_o <= 1'b1;
                                end else begin
                                    state   <= ST_REQ;
                                    cnt     <= CW'(TMO);
                                    req_o   <= 1'b1;
                                    we_o    <= (mop == MOP_STORE);
                                    maddr_o <= {addr_i[ADDR-1:LB], {LB{1'b0}}};
                                    be_o    <= al_be;
                                    wdata_o <= al_wdata;
                                    load_q  <= (mop == MOP_LOAD);
                                    sext_q  <= sext_i;
                                    size_q  <= size;
                                    lane_q  <= addr_i[LB-1:0];
                                    rd_q    <= rd_num_i;
                                end
                            end
                            default: err_o <= 1'b1;
                        endcase
                    end
                end
                ST_REQ: begin
                    // Ack takes priority over a simultaneous timeout expiry.
                    if (ack_i) begin
                        state <= ST_IDLE;
                        req_o <= 1'b0;
                        we_o  <= 1'b0;
                        if (load_q) begin
                            wb_o      <= 1'b1;
                            rd_num_o  <= rd_q;
                            rd_data_o <= al_ldata;
                        end
                    end else if (cnt == CW'(1)) begin
                        state <= ST_IDLE;
                        req_o <= 1'b0;
                        we_o  <= 1'b0;
                        err_o <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (TMO overridden to 4).
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        v_i;
    logic        stall_o;
    logic [1:0]  mop_i;
    logic [1:0]  size_i;
    logic        sext_i;
    logic [15:0] addr_i;
    logic [31:0] sdata_i;
    logic        wb_i;
    logic [4:0]  rd_num_i;
    logic [31:0] rd_data_i;
    logic        wb_o;
    logic [4:0]  rd_num_o;
    logic [31:0] rd_data_o;
    logic        req_o;
    logic        we_o;
    logic [15:0] maddr_o;
    logic [3:0]  be_o;
    logic [31:0] wdata_o;
    logic        ack_i;
    logic [31:0] rdata_i;
    logic        err_o;

    int n_asserts = 0;
    int n_fail    = 0;

    mem_stage #(
        .WORD (32),
        .ADDR (16),
        .W_RD (5),
        .TMO  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .v_i       (v_i),
        .stall_o   (stall_o),
        .mop_i     (mop_i),
        .size_i    (size_i),
        .sext_i    (sext_i),
        .addr_i    (addr_i),
        .sdata_i   (sdata_i),
        .wb_i      (wb_i),
        .rd_num_i  (rd_num_i),
        .rd_data_i (rd_data_i),
        .wb_o      (wb_o),
        .rd_num_o  (rd_num_o),
        .rd_data_o (rd_data_o),
        .req_o     (req_o),
        .we_o      (we_o),
        .maddr_o   (maddr_o),
        .be_o      (be_o),
        .wdata_o   (wdata_o),
        .ack_i     (ack_i),
        .rdata_i   (rdata_i),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [1:0] mop, input logic [1:0] sz, input logic sx,
                      input logic [15:0] a, input logic [31:0] sd, input logic [4:0] rd);
        v_i = 1'b1; mop_i = mop; size_i = sz; sext_i = sx;
        addr_i = a; sdata_i = sd; rd_num_i = rd;
        tick;
        v_i = 1'b0; mop_i = 2'b00;
    endtask

    initial begin
        rst = 1'b0; v_i = 1'b0; mop_i = 2'b00; size_i = 2'b00; sext_i = 1'b0;
        addr_i = '0; sdata_i = '0; wb_i = 1'b0; rd_num_i = '0; rd_data_i = '0;
        ack_i = 1'b0; rdata_i = '0;
        tick; tick;
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_req",   32'(req_o),   32'd0);
        chk("rst_we",    32'(we_o),    32'd0);
        chk("rst_wb",    32'(wb_o),    32'd0);
        chk("rst_err",   32'(err_o),   32'd0);
        chk("rst_maddr", 32'(maddr_o), 32'd0);
        chk("rst_be",    32'(be_o),    32'd0);
        chk("rst_wdata", wdata_o,      32'd0);
        chk("rst_rdnum", 32'(rd_num_o), 32'd0);
        chk("rst_rddat", rd_data_o,    32'd0);
        rst = 1'b1;
        tick;

        // ALU passthrough
        wb_i = 1'b1; rd_data_i = 32'h0000_1234;
        op(2'b00, 2'b00, 1'b0, 16'h0000, 32'h0, 5'd3);
        wb_i = 1'b0; rd_data_i = '0;
        chk("pass_wb",    32'(wb_o),     32'd1);
        chk("pass_rdnum", 32'(rd_num_o), 32'd3);
        chk("pass_data",  rd_data_o,     32'h0000_1234);
        chk("pass_req",   32'(req_o),    32'd0);
        tick;
        chk("pass_wb_off", 32'(wb_o), 32'd0);

        // byte load, sign-extended, ack in first REQ cycle
        op(2'b01, 2'b00, 1'b1, 16'h0003, 32'h0, 5'd7);
        chk("lb_stall", 32'(stall_o), 32'd1);
        chk("lb_req",   32'(req_o),   32'd1);
        chk("lb_we",    32'(we_o),    32'd0);
        chk("lb_be",    32'(be_o),    32'b1000);
        chk("lb_maddr", 32'(maddr_o), 32'h0000);
        ack_i = 1'b1; rdata_i = 32'h8012_3456;
        tick;
        ack_i = 1'b0;
        chk("lb_wb",    32'(wb_o),     32'd1);
        chk("lb_rdnum", 32'(rd_num_o), 32'd7);
        chk("lb_data",  rd_data_o,     32'hFFFF_FF80);
        chk("lb_req0",  32'(req_o),    32'd0);
        chk("lb_stall0", 32'(stall_o), 32'd0);

        // back-to-back half load, signed then unsigned
        op(2'b01, 2'b01, 1'b1, 16'h0002, 32'h0, 5'd9);
        chk("lh_be", 32'(be_o), 32'b1100);
        ack_i = 1'b1; rdata_i = 32'h9ABC_0000;
        tick;
        ack_i = 1'b0;
        chk("lh_sx", rd_data_o, 32'hFFFF_9ABC);
        op(2'b01, 2'b01, 1'b0, 16'h0012, 32'h0, 5'd10);
        chk("lhu_maddr", 32'(maddr_o), 32'h0010);
        ack_i = 1'b1; rdata_i = 32'hBEEF_1234;
        tick;
        ack_i = 1'b0;
        chk("lhu_data", rd_data_o,     32'h0000_BEEF);
        chk("lhu_rd",   32'(rd_num_o), 32'd10);

        // half store, ack in 4th REQ cycle coinciding with counter expiry
        op(2'b10, 2'b01, 1'b0, 16'h0002, 32'h0000_BEEF, 5'd4);
        chk("sh_be",    32'(be_o),    32'b1100);
        chk("sh_wdata", wdata_o,      32'hBEEF_BEEF);
        chk("sh_we",    32'(we_o),    32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) ack_i = 1'b1;
            chk("sh_stall", 32'(stall_o), 32'd1);
            chk("sh_hold",  wdata_o,      32'hBEEF_BEEF);
            chk("sh_wb",    32'(wb_o),    32'd0);
            tick;
            ack_i = 1'b0;
        end
        chk("sh_stall0", 32'(stall_o), 32'd0);
        chk("sh_req0",   32'(req_o),   32'd0);
        chk("sh_wb0",    32'(wb_o),    32'd0);
        chk("sh_err0",   32'(err_o),   32'd0);

        // misaligned word load
        op(2'b01, 2'b10, 1'b0, 16'h0001, 32'h0, 5'd5);
        chk("mis_err",   32'(err_o),   32'd1);
        chk("mis_req",   32'(req_o),   32'd0);
        chk("mis_stall", 32'(stall_o), 32'd0);
        chk("mis_wb",    32'(wb_o),    32'd0);
        tick;
        chk("mis_err0", 32'(err_o), 32'd0);

        // reserved size and reserved mop
        op(2'b01, 2'b11, 1'b0, 16'h0000, 32'h0, 5'd5);
        chk("rsz_err", 32'(err_o), 32'd1);
        chk("rsz_req", 32'(req_o), 32'd0);
        op(2'b11, 2'b10, 1'b0, 16'h0000, 32'h0, 5'd5);
        chk("rmop_err", 32'(err_o), 32'd1);
        chk("rmop_wb",  32'(wb_o),  32'd0);

        // timeout: no ack
        op(2'b01, 2'b10, 1'b0, 16'h0004, 32'h0, 5'd6);
        chk("to_maddr", 32'(maddr_o), 32'h0004);
        for (int i = 0; i < 4; i++) begin
            chk("to_req", 32'(req_o), 32'd1);
            chk("to_err", 32'(err_o), 32'd0);
            tick;
        end
        chk("to_req0",  32'(req_o),   32'd0);
        chk("to_err1",  32'(err_o),   32'd1);
        chk("to_wb",    32'(wb_o),    32'd0);
        chk("to_stall", 32'(stall_o), 32'd0);
        wb_i = 1'b1; rd_data_i = 32'hCAFE_0001;
        op(2'b00, 2'b00, 1'b0, 16'h0000, 32'h0, 5'd12);
        wb_i = 1'b0;
        chk("to_next_wb",   32'(wb_o), 32'd1);
        chk("to_next_data", rd_data_o, 32'hCAFE_0001);

        // reset during REQ, late ack ignored
        op(2'b01, 2'b10, 1'b0, 16'h0008, 32'h0, 5'd8);
        chk("ar_req1", 32'(req_o), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("ar_req0",   32'(req_o),   32'd0);
        chk("ar_stall0", 32'(stall_o), 32'd0);
        #2 rst = 1'b1;
        ack_i = 1'b1; rdata_i = 32'h1111_1111;
        tick;
        ack_i = 1'b0;
        chk("ar_wb",  32'(wb_o),  32'd0);
        chk("ar_req", 32'(req_o), 32'd0);
        tick;
        chk("ar_wb2", 32'(wb_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
